// File: rtl/number_grid_controller_if.sv
// Pixel query, hit/round control and tile-status bundle between the VGA
// front end and the number grid controller.
interface number_grid_controller_if;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        startOfFrame;
  logic        singleHit;
  logic        newRound;
  logic        numDR;
  logic [4:0]  tileIdx;
  logic [5:0]  offsetX;
  logic [5:0]  offsetY;
  logic [3:0]  tileDigit;
  logic [31:0] aliveMask;
  logic [15:0] score;
  logic        allCleared;

  modport master (
    output pixelX, pixelY, startOfFrame, singleHit, newRound,
    input  numDR, tileIdx, offsetX, offsetY, tileDigit, aliveMask, score, allCleared
  );

  modport slave (
    input  pixelX, pixelY, startOfFrame, singleHit, newRound,
    output numDR, tileIdx, offsetX, offsetY, tileDigit, aliveMask, score, allCleared
  );
endinterface

// File: rtl/number_grid_controller.sv
// Grid of random-digit tiles: loads digits from an LFSR, resolves the pixel
// under the beam to a tile, scores hits and respawns hit tiles after a delay.
module number_grid_controller #(
  parameter int          ROWS           = 4,
  parameter int          COLS           = 3,
  parameter int          TOP_LEFT_X     = 150,
  parameter int          TOP_LEFT_Y     = 100,
  parameter int          X_DIFF         = 50,
  parameter int          Y_DIFF         = 50,
  parameter int          TILE_W         = 32,
  parameter int          TILE_H         = 32,
  parameter int          RESPAWN_FRAMES = 60,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input logic clk,
  input logic reset,
  number_grid_controller_if.slave bus
);

  localparam int         N        = ROWS * COLS;
  localparam logic [4:0] LAST_IDX = 5'(N - 1);
  localparam logic [7:0] RESPAWN  = 8'(RESPAWN_FRAMES);

  // state | meaning
  // IDLE  | one cycle after reset release
  // LOAD  | writing tile load_idx_q with a fresh digit, one tile per cycle
  // RUN   | hits scored, dead tiles count frames down to respawn
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t       state_q, state_d;
  logic [4:0]   load_idx_q, load_idx_d;
  logic         load_en;
  logic         run;
  logic [15:0]  lfsr;
  logic [3:0]   new_digit;
  logic [N-1:0] alive;
  logic [N-1:0] in_tile;
  logic [N-1:0] hit_mask;
  logic [N-1:0] expire_mask;
  logic [N-1:0] alive_run;
  logic [3:0]   digit [N];
  logic [7:0]   cnt [N];
  logic [11:0]  dx [N];
  logic [11:0]  dy [N];
  logic [15:0]  score;
  logic [16:0]  score_sum;
  logic         all_cleared;
  logic         hit_en;
  logic         m_hit;
  logic [4:0]   m_idx;
  logic [5:0]   m_dx;
  logic [5:0]   m_dy;
  logic [3:0]   m_digit;
  logic         num_dr_q;
  logic [4:0]   tile_idx_q;
  logic [5:0]   offset_x_q;
  logic [5:0]   offset_y_q;
  logic [3:0]   tile_digit_q;
  logic [31:0]  mask_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign new_digit = (lfsr[3:0] < 4'd10) ? lfsr[3:0] : lfsr[3:0] - 4'd10;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      load_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      load_idx_q <= load_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    load_idx_d = load_idx_q;
    load_en    = 1'b0;
    case (state_q)
      IDLE: begin
        state_d    = LOAD;
        load_idx_d = '0;
      end
      LOAD: begin
        load_en = 1'b1;
        if (load_idx_q == LAST_IDX) begin
          state_d    = RUN;
          load_idx_d = '0;
        end else begin
          load_idx_d = load_idx_q + 5'd1;
        end
      end
      RUN: ;
      default: state_d = IDLE;
    endcase
    if (bus.newRound) begin
      state_d    = LOAD;
      load_idx_d = '0;
      load_en    = 1'b0;
    end
  end

  assign run = (state_q == RUN) && !bus.newRound;

  // 12-bit arithmetic keeps pixel - origin from aliasing into the tile window
  for (genvar g = 0; g < N; g++) begin : g_tile
    localparam int X0 = TOP_LEFT_X + (g / ROWS) * X_DIFF;
    localparam int Y0 = TOP_LEFT_Y + (g % ROWS) * Y_DIFF;
    assign dx[g] = {1'b0, bus.pixelX} - 12'(X0);
    assign dy[g] = {1'b0, bus.pixelY} - 12'(Y0);
    assign in_tile[g] = ({1'b0, bus.pixelX} >= 12'(X0)) && (dx[g] < 12'(TILE_W)) &&
                        ({1'b0, bus.pixelY} >= 12'(Y0)) && (dy[g] < 12'(TILE_H)) &&
                        alive[g];
  end

  always_comb begin
    m_hit   = 1'b0;
    m_idx   = '0;
    m_dx    = '0;
    m_dy    = '0;
    m_digit = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_tile[i]) begin
        m_hit   = 1'b1;
        m_idx   = 5'(i);
        m_dx    = dx[i][5:0];
        m_dy    = dy[i][5:0];
        m_digit = digit[i];
      end
    end
  end

  assign hit_en = run && bus.singleHit && m_hit;

  always_comb begin
    hit_mask    = '0;
    expire_mask = '0;
    for (int i = 0; i < N; i++) begin
      hit_mask[i]    = hit_en && (m_idx == 5'(i));
      expire_mask[i] = run && !alive[i] && (cnt[i] == 8'd0);
    end
  end

  assign alive_run = (alive & ~hit_mask) | expire_mask;
  assign score_sum = {1'b0, score} + {13'd0, m_digit};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alive       <= '0;
      score       <= '0;
      all_cleared <= 1'b0;
      for (int i = 0; i < N; i++) begin
        digit[i] <= '0;
        cnt[i]   <= '0;
      end
    end else begin
      all_cleared <= run && (|alive) && (alive_run == '0);
      if (bus.newRound) begin
        alive <= '0;
        for (int i = 0; i < N; i++) cnt[i] <= '0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (load_en && (load_idx_q == 5'(i))) begin
            alive[i] <= 1'b1;
            digit[i] <= new_digit;
            cnt[i]   <= '0;
          end else if (hit_mask[i]) begin
            alive[i] <= 1'b0;
            cnt[i]   <= RESPAWN;
          end else if (expire_mask[i]) begin
            alive[i] <= 1'b1;
            digit[i] <= new_digit;
          end else if (run && !alive[i] && bus.startOfFrame && (cnt[i] != 8'd0)) begin
            cnt[i] <= cnt[i] - 8'd1;
          end
        end
        if (hit_en) score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_dr_q     <= 1'b0;
      tile_idx_q   <= '0;
      offset_x_q   <= '0;
      offset_y_q   <= '0;
      tile_digit_q <= '0;
    end else begin
      num_dr_q     <= m_hit;
      tile_idx_q   <= m_idx;
      offset_x_q   <= m_dx;
      offset_y_q   <= m_dy;
      tile_digit_q <= m_digit;
    end
  end

  always_comb begin
    mask_ext        = '0;
    mask_ext[N-1:0] = alive;
  end

  assign bus.numDR      = num_dr_q;
  assign bus.tileIdx    = tile_idx_q;
  assign bus.offsetX    = offset_x_q;
  assign bus.offsetY    = offset_y_q;
  assign bus.tileDigit  = tile_digit_q;
  assign bus.aliveMask  = mask_ext;
  assign bus.score      = score;
  assign bus.allCleared = all_cleared;

endmodule

// File: tb/tb_number_grid_controller.sv
// Directed bench for number_grid_controller: load, pixel lookup, hits,
// respawn, clear pulse, newRound priority, reset and score saturation.
module tb_number_grid_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  logic [15:0] m_lfsr;
  logic [3:0]  exp_digit [12];
  logic [11:0] exp_alive;
  int          m_score;

  number_grid_controller_if bus ();

  number_grid_controller #(.ROWS(4), .COLS(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // reference LFSR: Fibonacci, taps 16,14,13,11, shifting toward the MSB
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  initial begin
    #950000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_digit(input logic [15:0] v);
    logic [3:0] lo;
    lo = v[3:0];
    return (lo < 4'd10) ? lo : lo - 4'd10;
  endfunction

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_pixel(input int x, input int y);
    bus.pixelX = 11'(x);
    bus.pixelY = 11'(y);
  endtask

  // entered at a negedge with the DUT in LOAD and tile 0 next
  task automatic load_round(input bit chk);
    for (int k = 0; k < 12; k++) begin
      if (chk) check($sformatf("load_mask%0d", k), bus.aliveMask, (32'd1 << k) - 32'd1);
      exp_digit[k] = ref_digit(m_lfsr);
      tick();
    end
    exp_alive = 12'hFFF;
    if (chk) check("load_done", bus.aliveMask, 32'hFFF);
  endtask

  task automatic new_round();
    bus.newRound = 1'b1;
    tick();
    bus.newRound = 1'b0;
    exp_alive = '0;
  endtask

  task automatic hit_tile(input int i);
    set_pixel(150 + 50 * (i / 4) + 3, 100 + 50 * (i % 4) + 3);
    bus.singleHit = 1'b1;
    tick();
    bus.singleHit = 1'b0;
    if (exp_alive[i]) begin
      exp_alive[i] = 1'b0;
      m_score = sat16(m_score + int'(exp_digit[i]));
    end
  endtask

  task automatic query_tile(input int i);
    set_pixel(150 + 50 * (i / 4), 100 + 50 * (i % 4));
    tick();
    check($sformatf("digit_tile%0d", i), 32'({bus.numDR, bus.tileIdx, bus.tileDigit}),
          32'({1'b1, 5'(i), exp_digit[i]}));
  endtask

  initial begin
    int pulses;
    int base;
    int sum_exp;
    int rounds;
    bit found;
    bus.pixelX = '0;
    bus.pixelY = '0;
    bus.startOfFrame = 1'b0;
    bus.singleHit = 1'b0;
    bus.newRound = 1'b0;
    m_score = 0;
    exp_alive = '0;
    for (int k = 0; k < 12; k++) exp_digit[k] = '0;

    tick();
    tick();
    check("rst_alive", bus.aliveMask, 32'd0);
    check("rst_score", 32'(bus.score), 32'd0);
    check("rst_pix", 32'({bus.numDR, bus.tileIdx, bus.offsetX, bus.offsetY, bus.tileDigit}), 32'd0);
    check("rst_clear", 32'(bus.allCleared), 32'd0);

    reset = 1'b0;
    tick();
    load_round(1'b1);
    for (int i = 0; i < 12; i++) query_tile(i);

    set_pixel(150, 100);
    tick();
    check("pix_150_100", 32'({bus.numDR, bus.tileIdx, bus.offsetX, bus.offsetY}), 32'({1'b1, 5'd0, 6'd0, 6'd0}));
    set_pixel(181, 131);
    tick();
    check("pix_181_131", 32'({bus.numDR, bus.tileIdx, bus.offsetX, bus.offsetY}), 32'({1'b1, 5'd0, 6'd31, 6'd31}));
    set_pixel(182, 100);
    tick();
    check("pix_182_100", 32'({bus.numDR, bus.tileIdx, bus.offsetX, bus.offsetY, bus.tileDigit}), 32'd0);
    set_pixel(200, 150);
    tick();
    check("pix_200_150", 32'({bus.numDR, bus.tileIdx, bus.offsetX, bus.offsetY, bus.tileDigit}),
          32'({1'b1, 5'd5, 6'd0, 6'd0, exp_digit[5]}));

    // single hit on tile 5, repeated hit while dead, then respawn
    base = m_score;
    set_pixel(210, 160);
    bus.singleHit = 1'b1;
    tick();
    bus.singleHit = 1'b0;
    exp_alive[5] = 1'b0;
    m_score = sat16(m_score + int'(exp_digit[5]));
    check("hit5_alive", 32'(bus.aliveMask[5]), 32'd0);
    check("hit5_score", 32'(bus.score), 32'(base + int'(exp_digit[5])));
    hit_tile(5);
    check("hit5_again", 32'(bus.score), 32'(m_score));
    set_pixel(0, 0);
    for (int p = 1; p <= 60; p++) begin
      bus.startOfFrame = 1'b1;
      tick();
      bus.startOfFrame = 1'b0;
      if (p < 60) tick();
      if (p == 59) check("respawn_59", 32'(bus.aliveMask[5]), 32'd0);
    end
    check("respawn_60", 32'(bus.aliveMask[5]), 32'd0);
    exp_digit[5] = ref_digit(m_lfsr);
    tick();
    exp_alive[5] = 1'b1;
    check("respawn_alive", bus.aliveMask, 32'hFFF);
    query_tile(5);

    // clear the whole grid in one frame
    base = m_score;
    sum_exp = 0;
    for (int i = 0; i < 12; i++) sum_exp += int'(exp_digit[i]);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      hit_tile(i);
      if (bus.allCleared) pulses++;
    end
    for (int j = 0; j < 3; j++) begin
      tick();
      if (bus.allCleared) pulses++;
    end
    check("clear_pulses", 32'(pulses), 32'd1);
    check("clear_alive", bus.aliveMask, 32'd0);
    check("clear_score", 32'(bus.score), 32'(sat16(base + sum_exp)));

    new_round();
    load_round(1'b1);

    // newRound beats a simultaneous hit, keeps score, no clear pulse
    set_pixel(153, 103);
    bus.singleHit = 1'b1;
    bus.newRound = 1'b1;
    tick();
    bus.singleHit = 1'b0;
    bus.newRound = 1'b0;
    exp_alive = '0;
    check("nr_hit_score", 32'(bus.score), 32'(m_score));
    check("nr_hit_alive", bus.aliveMask, 32'd0);
    check("nr_no_clear", 32'(bus.allCleared), 32'd0);
    load_round(1'b1);

    // reset in the middle of LOAD
    set_pixel(150, 100);
    new_round();
    tick();
    tick();
    tick();
    check("midload_mask", bus.aliveMask, 32'h7);
    check("midload_numdr", 32'(bus.numDR), 32'd1);
    reset = 1'b1;
    #1;
    check("rstmid_alive", bus.aliveMask, 32'd0);
    check("rstmid_score", 32'(bus.score), 32'd0);
    check("rstmid_pix", 32'({bus.numDR, bus.tileIdx, bus.offsetX, bus.offsetY, bus.tileDigit}), 32'd0);
    check("rstmid_clear", 32'(bus.allCleared), 32'd0);
    m_score = 0;
    exp_alive = '0;
    tick();
    reset = 1'b0;
    tick();
    load_round(1'b1);
    set_pixel(0, 0);

    // drive the score to exactly 65530, then hit a 9 to saturate
    rounds = 0;
    while (m_score < 65530 && rounds < 2500) begin
      for (int i = 0; i < 12; i++)
        if (exp_digit[i] != 4'd0 && m_score + int'(exp_digit[i]) <= 65530) hit_tile(i);
      new_round();
      load_round(1'b0);
      rounds++;
    end
    check("sat_pre", 32'(bus.score), 32'd65530);
    found = 1'b0;
    rounds = 0;
    while (!found && rounds < 100) begin
      for (int i = 0; i < 12; i++) begin
        if (!found && exp_digit[i] == 4'd9) begin
          hit_tile(i);
          found = 1'b1;
        end
      end
      if (!found) begin
        new_round();
        load_round(1'b0);
      end
      rounds++;
    end
    check("sat_found9", 32'(found), 32'd1);
    check("sat_ffff", 32'(bus.score), 32'hFFFF);
    for (int i = 0; i < 12; i++) if (exp_alive[i] && exp_digit[i] != 4'd0) hit_tile(i);
    check("sat_hold", 32'(bus.score), 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
